// File: rtl/op_dispatch_pkg.sv
// Shared types and widths for the op_dispatch issue stage.
// Opcode encodings not listed here are legal on the bus and execute on the ALU.
package op_dispatch_pkg;

  localparam int unsigned OPND_W = 8;   // operand / store data width
  localparam int unsigned ADDR_W = 12;  // load/store address width
  localparam int unsigned RES_W  = 16;  // result / writeback data width

  typedef enum logic [3:0] {
    OP_NOP   = 4'h0,
    OP_ADD   = 4'h1,
    OP_SUB   = 4'h2,
    OP_MUL   = 4'h3,
    OP_AND   = 4'h4,
    OP_OR    = 4'h5,
    OP_XOR   = 4'h6,
    OP_LOAD  = 4'h8,
    OP_STORE = 4'h9
  } opcode_t;

endpackage

// File: rtl/op_dispatch.sv
// op_dispatch: single-issue dispatcher in front of the ALU, load and store units.
// Accepts one decoded instruction on a valid/ready handshake, holds the chosen
// unit's start until its end, then emits a one-cycle tagged writeback pulse.
//
// Ports:
//   clk, rst                  clock, asynchronous active-low reset
//   instr_*                   upstream instruction handshake and payload
//   alu_* / start_alu / end_alu / result_alu         ALU interface
//   ld_addr / start_load / end_load / result_load    load unit interface
//   st_addr / st_data / start_store / end_store      store unit interface
//   wb_valid / wb_tag / wb_data / wb_is_store        register-file writeback
//   busy                      instruction in flight (EXEC or WB)
//   err                       watchdog abort marker on the writeback pulse
//
// Build option: define OP_DISPATCH_WATCHDOG_EN to abort an EXEC that lasts
// TIMEOUT cycles without an end_* (writes back 16'hFFFF with err=1).
// Without it EXEC waits indefinitely and err is tied low.
//
// All outputs are flops loaded from the next-state decode, so they change
// only on clk and clear asynchronously with rst.
module op_dispatch
  import op_dispatch_pkg::*;
#(
  parameter int unsigned TAG_W   = 4,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              instr_valid,
  output logic              instr_ready,
  input  opcode_t           instr_op,
  input  logic [OPND_W-1:0] instr_a,
  input  logic [OPND_W-1:0] instr_b,
  input  logic [ADDR_W-1:0] instr_addr,
  input  logic [TAG_W-1:0]  instr_tag,
  output logic [OPND_W-1:0] alu_a,
  output logic [OPND_W-1:0] alu_b,
  output opcode_t           alu_op,
  output logic              start_alu,
  input  logic              end_alu,
  input  logic [RES_W-1:0]  result_alu,
  output logic [ADDR_W-1:0] ld_addr,
  output logic              start_load,
  input  logic              end_load,
  input  logic [RES_W-1:0]  result_load,
  output logic [ADDR_W-1:0] st_addr,
  output logic [OPND_W-1:0] st_data,
  output logic              start_store,
  input  logic              end_store,
  output logic              wb_valid,
  output logic [TAG_W-1:0]  wb_tag,
  output logic [RES_W-1:0]  wb_data,
  output logic              wb_is_store,
  output logic              busy,
  output logic              err
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_WB   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  opcode_t           op_q, op_d;
  logic [OPND_W-1:0] a_q, a_d, b_q, b_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [TAG_W-1:0]  tag_q, tag_d;
  logic [RES_W-1:0]  res_q, res_d;

  logic              end_sel;
  logic [RES_W-1:0]  res_sel;
  logic              go_alu, go_load, go_store, in_wb;

`ifdef OP_DISPATCH_WATCHDOG_EN
  localparam int unsigned WD_W = (TIMEOUT > 255) ? $clog2(TIMEOUT + 1) : 8;
  logic [WD_W-1:0] wd_q;
  logic            abort_q, abort_d;
  logic            timeout_hit;

  // wd_q holds (EXEC cycles so far - 1); it is 0 in the first EXEC cycle.
  assign timeout_hit = (wd_q == WD_W'(TIMEOUT - 1));

  // Watchdog counter: zero outside EXEC, so it restarts on every EXEC entry.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wd_q <= '0;
    end else if (state_q == S_EXEC) begin
      wd_q <= wd_q + WD_W'(1);
    end else begin
      wd_q <= '0;
    end
  end
`else
  logic unused_timeout;
  assign unused_timeout = ^TIMEOUT;
`endif

  // Completion and result of the unit selected by the latched opcode;
  // end_* from the other units is never looked at.
  always_comb begin
    end_sel = 1'b0;
    res_sel = '0;
    case (op_q)
      OP_LOAD: begin
        end_sel = end_load;
        res_sel = result_load;
      end
      OP_STORE: begin
        end_sel = end_store;
        res_sel = '0;
      end
      default: begin
        end_sel = end_alu;
        res_sel = result_alu;
      end
    endcase
  end

  // Next-state and payload capture.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    addr_d  = addr_q;
    tag_d   = tag_q;
    res_d   = res_q;
`ifdef OP_DISPATCH_WATCHDOG_EN
    abort_d = abort_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (instr_valid && instr_ready) begin
          op_d   = instr_op;
          a_d    = instr_a;
          b_d    = instr_b;
          addr_d = instr_addr;
          tag_d  = instr_tag;
`ifdef OP_DISPATCH_WATCHDOG_EN
          abort_d = 1'b0;
`endif
          if (instr_op == OP_NOP) begin
            res_d   = '0;
            state_d = S_WB;
          end else begin
            state_d = S_EXEC;
          end
        end
      end
      S_EXEC: begin
        if (end_sel) begin
          res_d   = res_sel;
          state_d = S_WB;
        end
`ifdef OP_DISPATCH_WATCHDOG_EN
        else if (timeout_hit) begin
          res_d   = '1;
          abort_d = 1'b1;
          state_d = S_WB;
        end
`endif
      end
      // WB always returns to IDLE, which keeps every start low for the
      // cycle after EXEC so the units can drop back to idle.
      S_WB:    state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output decode from the next state; loaded into the output flops below.
  always_comb begin
    go_alu   = 1'b0;
    go_load  = 1'b0;
    go_store = 1'b0;
    if (state_d == S_EXEC) begin
      case (op_d)
        OP_LOAD:  go_load  = 1'b1;
        OP_STORE: go_store = 1'b1;
        default:  go_alu   = 1'b1;
      endcase
    end
    in_wb = (state_d == S_WB);
  end

  // State and captured payload.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      op_q    <= OP_NOP;
      a_q     <= '0;
      b_q     <= '0;
      addr_q  <= '0;
      tag_q   <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      addr_q  <= addr_d;
      tag_q   <= tag_d;
      res_q   <= res_d;
    end
  end

  // Output flops; unit-side payloads are zero unless that unit is started.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      instr_ready <= 1'b0;
      busy        <= 1'b0;
      start_alu   <= 1'b0;
      alu_a       <= '0;
      alu_b       <= '0;
      alu_op      <= OP_NOP;
      start_load  <= 1'b0;
      ld_addr     <= '0;
      start_store <= 1'b0;
      st_addr     <= '0;
      st_data     <= '0;
      wb_valid    <= 1'b0;
      wb_tag      <= '0;
      wb_data     <= '0;
      wb_is_store <= 1'b0;
    end else begin
      instr_ready <= (state_d == S_IDLE);
      busy        <= (state_d != S_IDLE);
      start_alu   <= go_alu;
      alu_a       <= go_alu ? a_d : '0;
      alu_b       <= go_alu ? b_d : '0;
      alu_op      <= go_alu ? op_d : OP_NOP;
      start_load  <= go_load;
      ld_addr     <= go_load ? addr_d : '0;
      start_store <= go_store;
      st_addr     <= go_store ? addr_d : '0;
      st_data     <= go_store ? b_d : '0;
      wb_valid    <= in_wb;
      wb_tag      <= in_wb ? tag_d : '0;
      wb_data     <= in_wb ? res_d : '0;
      wb_is_store <= in_wb && (op_d == OP_STORE);
    end
  end

`ifdef OP_DISPATCH_WATCHDOG_EN
  // Abort marker and err strobe; err only accompanies an aborted writeback.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      abort_q <= 1'b0;
      err     <= 1'b0;
    end else begin
      abort_q <= abort_d;
      err     <= in_wb && abort_d;
    end
  end
`else
  assign err = 1'b0;
`endif

endmodule

// File: tb/tb_op_dispatch.sv
// Testbench for op_dispatch: behavioural unit models drive end_*/result_*,
// a transaction-level model predicts every output each cycle, and directed
// tests pin hand-computed writeback values, start lengths and latencies.
module tb_op_dispatch;
  import op_dispatch_pkg::*;

  localparam int unsigned TB_TIMEOUT = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        instr_valid, instr_ready;
  opcode_t     instr_op;
  logic [7:0]  instr_a, instr_b;
  logic [11:0] instr_addr;
  logic [3:0]  instr_tag;
  logic [7:0]  alu_a, alu_b;
  opcode_t     alu_op;
  logic        start_alu, end_alu;
  logic [15:0] result_alu;
  logic [11:0] ld_addr;
  logic        start_load, end_load;
  logic [15:0] result_load;
  logic [11:0] st_addr;
  logic [7:0]  st_data;
  logic        start_store, end_store;
  logic        wb_valid, wb_is_store, busy, err;
  logic [3:0]  wb_tag;
  logic [15:0] wb_data;

  op_dispatch #(.TAG_W(4), .TIMEOUT(TB_TIMEOUT)) dut (
    .clk(clk), .rst(rst),
    .instr_valid(instr_valid), .instr_ready(instr_ready), .instr_op(instr_op),
    .instr_a(instr_a), .instr_b(instr_b), .instr_addr(instr_addr), .instr_tag(instr_tag),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op), .start_alu(start_alu),
    .end_alu(end_alu), .result_alu(result_alu),
    .ld_addr(ld_addr), .start_load(start_load), .end_load(end_load), .result_load(result_load),
    .st_addr(st_addr), .st_data(st_data), .start_store(start_store), .end_store(end_store),
    .wb_valid(wb_valid), .wb_tag(wb_tag), .wb_data(wb_data), .wb_is_store(wb_is_store),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // ---------------- execution unit models ----------------
  int alu_lat, ld_lat, st_lat;
  logic [7:0] ld_data;
  int alu_cnt, ld_cnt, st_cnt;

  function automatic logic [15:0] alu_fn(input opcode_t op, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] wa, wb;
    wa = {8'h00, a};
    wb = {8'h00, b};
    case (op)
      OP_ADD:  return wa + wb;
      OP_SUB:  return wa - wb;
      OP_MUL:  return wa * wb;
      OP_AND:  return wa & wb;
      OP_OR:   return wa | wb;
      OP_XOR:  return wa ^ wb;
      default: return 16'h0000;
    endcase
  endfunction

  // ALU: end after alu_lat start cycles, held until start drops.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_alu <= 1'b0; result_alu <= '0; alu_cnt = 0;
    end else if (!start_alu) begin
      end_alu <= 1'b0; alu_cnt = 0;
    end else if (!end_alu) begin
      alu_cnt++;
      if (alu_cnt >= alu_lat) begin
        end_alu <= 1'b1;
        result_alu <= alu_fn(alu_op, alu_a, alu_b);
      end
    end
  end

  // Load / store: one-cycle end pulse after *_lat start cycles.
  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_load <= 1'b0; result_load <= '0; ld_cnt = 0;
    end else begin
      end_load <= 1'b0; result_load <= '0;
      if (!start_load) ld_cnt = 0;
      else if (!end_load) begin
        ld_cnt++;
        if (ld_cnt >= ld_lat) begin
          end_load <= 1'b1;
          result_load <= {8'h00, ld_data};
        end
      end
    end
  end

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      end_store <= 1'b0; st_cnt = 0;
    end else begin
      end_store <= 1'b0;
      if (!start_store) st_cnt = 0;
      else if (!end_store) begin
        st_cnt++;
        if (st_cnt >= st_lat) end_store <= 1'b1;
      end
    end
  end

  // ---------------- transaction-level reference model ----------------
  // m_exec: an accepted instruction is waiting on its unit.
  // m_wb:   this cycle is the writeback pulse of the last instruction.
  bit          m_armed, m_exec, m_wb, m_err;
  opcode_t     m_op;
  logic [7:0]  m_a, m_b;
  logic [11:0] m_addr;
  logic [3:0]  m_tag;
  logic [15:0] m_data;
  int          m_exec_n;

  always @(posedge clk or negedge rst) begin : model
    bit ready_now, fin;
    if (!rst) begin
      m_armed = 0; m_exec = 0; m_wb = 0; m_err = 0; m_exec_n = 0;
    end else begin
      ready_now = m_armed && !m_exec && !m_wb;
      m_armed = 1;
      if (m_wb) begin
        m_wb = 0;
      end else if (m_exec) begin
        m_exec_n++;
        fin = (m_op == OP_LOAD) ? end_load : (m_op == OP_STORE) ? end_store : end_alu;
        if (fin) begin
          m_data = (m_op == OP_LOAD) ? result_load : (m_op == OP_STORE) ? 16'h0000 : result_alu;
          m_err = 0; m_exec = 0; m_wb = 1;
        end
`ifdef OP_DISPATCH_WATCHDOG_EN
        else if (m_exec_n == int'(TB_TIMEOUT)) begin
          m_data = 16'hFFFF; m_err = 1; m_exec = 0; m_wb = 1;
        end
`endif
      end else if (ready_now && instr_valid) begin
        m_op = instr_op; m_a = instr_a; m_b = instr_b; m_addr = instr_addr; m_tag = instr_tag;
        m_exec_n = 0; m_err = 0;
        if (instr_op == OP_NOP) begin
          m_data = 16'h0000; m_wb = 1;
        end else begin
          m_exec = 1;
        end
      end
    end
  end

  // Every-cycle comparison against the model.
  always @(negedge clk) begin : cmp
    bit ga, gl, gs;
    ga = m_exec && !(m_op == OP_LOAD || m_op == OP_STORE);
    gl = m_exec && (m_op == OP_LOAD);
    gs = m_exec && (m_op == OP_STORE);
    chk("instr_ready", 32'(instr_ready), 32'(m_armed && !m_exec && !m_wb));
    chk("busy", 32'(busy), 32'(m_exec || m_wb));
    chk("start_alu", 32'(start_alu), 32'(ga));
    chk("start_load", 32'(start_load), 32'(gl));
    chk("start_store", 32'(start_store), 32'(gs));
    chk("alu_a", 32'(alu_a), ga ? 32'(m_a) : 32'h0);
    chk("alu_b", 32'(alu_b), ga ? 32'(m_b) : 32'h0);
    chk("alu_op", 32'(alu_op), ga ? 32'(m_op) : 32'h0);
    chk("ld_addr", 32'(ld_addr), gl ? 32'(m_addr) : 32'h0);
    chk("st_addr", 32'(st_addr), gs ? 32'(m_addr) : 32'h0);
    chk("st_data", 32'(st_data), gs ? 32'(m_b) : 32'h0);
    chk("wb_valid", 32'(wb_valid), 32'(m_wb));
    if (m_wb) begin
      chk("wb_tag", 32'(wb_tag), 32'(m_tag));
      chk("wb_data", 32'(wb_data), 32'(m_data));
      chk("wb_is_store", 32'(wb_is_store), 32'(m_op == OP_STORE));
      chk("err", 32'(err), 32'(m_err));
    end
  end

  // ---------------- observation for directed checks ----------------
  typedef struct {
    logic [3:0]  tag;
    logic [15:0] data;
    logic        st;
    logic        er;
    int          cyc;
  } rec_t;

  rec_t wbq[$];
  int n_sa, n_sl, n_ss;
  logic [11:0] last_st_addr;
  logic [7:0]  last_st_data;

  always @(negedge clk) begin
    if (wb_valid) wbq.push_back('{tag: wb_tag, data: wb_data, st: wb_is_store, er: err, cyc: cyc});
    if (start_alu) n_sa++;
    if (start_load) n_sl++;
    if (start_store) begin
      n_ss++;
      last_st_addr = st_addr;
      last_st_data = st_data;
    end
  end

  // Present an instruction and hold it until it is taken; returns the
  // accept cycle. Called and returns at posedge+#1.
  task automatic issue(input opcode_t op, input logic [7:0] a, input logic [7:0] b,
                       input logic [11:0] addr, input logic [3:0] tag, output int acc);
    instr_valid = 1'b1; instr_op = op; instr_a = a; instr_b = b;
    instr_addr = addr; instr_tag = tag;
    acc = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (instr_ready) begin
        acc = cyc;
        break;
      end
    end
    if (acc < 0) chk("accept_timeout", 32'h0, 32'h1);
    @(posedge clk); #1;
  endtask

  task automatic wait_wb(output rec_t r);
    bit got;
    got = 0;
    r = '{tag: 4'h0, data: 16'h0, st: 1'b0, er: 1'b0, cyc: 0};
    for (int i = 0; i < 200 && !got; i++) begin
      if (wbq.size() > 0) begin
        r = wbq.pop_front();
        got = 1;
      end else begin
        @(negedge clk);
      end
    end
    if (!got) chk("wb_timeout", 32'h0, 32'h1);
  endtask

  task automatic settle();
    repeat (3) @(posedge clk);
    #1;
  endtask

  rec_t r;
  int acc;

  initial begin
    rst = 1'b0; instr_valid = 1'b0; instr_op = OP_NOP; instr_a = '0; instr_b = '0;
    instr_addr = '0; instr_tag = '0;
    alu_lat = 1; ld_lat = 1; st_lat = 1; ld_data = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ready", 32'(instr_ready), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_wb_valid", 32'(wb_valid), 32'h0);
    chk("rst_starts", 32'({start_alu, start_load, start_store}), 32'h0);
    rst = 1'b1;
    settle();

    // ADD 5+3, tag 3, single-cycle ALU
    n_sa = 0;
    issue(OP_ADD, 8'h05, 8'h03, 12'h000, 4'd3, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("add_data", 32'(r.data), 32'h0008);
    chk("add_tag", 32'(r.tag), 32'h3);
    chk("add_latency", 32'(r.cyc - acc), 32'd3);
    chk("add_start_len", 32'(n_sa), 32'd2);
    settle();

    // MUL 0x10*0x10, three start cycles
    alu_lat = 2; n_sa = 0;
    issue(OP_MUL, 8'h10, 8'h10, 12'h000, 4'd4, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("mul_data", 32'(r.data), 32'h0100);
    chk("mul_latency", 32'(r.cyc - acc), 32'd4);
    chk("mul_start_len", 32'(n_sa), 32'd3);
    while (cyc <= r.cyc) @(negedge clk);
    chk("mul_ready_after_wb", 32'(instr_ready), 32'h1);
    @(posedge clk); #1;
    settle();

    // LOAD 0x2A0, unit answers after 5 waiting cycles with 0x5C
    ld_lat = 5; ld_data = 8'h5C; n_sl = 0;
    issue(OP_LOAD, 8'h00, 8'h00, 12'h2A0, 4'd1, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("load_data", 32'(r.data), 32'h005C);
    chk("load_start_len", 32'(n_sl), 32'd6);
    chk("load_is_store", 32'(r.st), 32'h0);
    settle();

    // STORE 0xA5 to 0x011
    st_lat = 2; n_ss = 0;
    issue(OP_STORE, 8'h00, 8'hA5, 12'h011, 4'd2, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("store_addr", 32'(last_st_addr), 32'h011);
    chk("store_data", 32'(last_st_data), 32'hA5);
    chk("store_is_store", 32'(r.st), 32'h1);
    chk("store_wb_data", 32'(r.data), 32'h0000);
    chk("store_start_len", 32'(n_ss), 32'd3);
    settle();

    // Back-to-back ADD, NOP, SUB with instr_valid held high
    alu_lat = 1; n_sa = 0; n_sl = 0; n_ss = 0;
    issue(OP_ADD, 8'h01, 8'h02, 12'h000, 4'd5, acc);
    issue(OP_NOP, 8'h77, 8'h66, 12'h555, 4'd6, acc);
    issue(OP_SUB, 8'h09, 8'h04, 12'h000, 4'd7, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("b2b0_tag", 32'(r.tag), 32'h5);
    chk("b2b0_data", 32'(r.data), 32'h0003);
    wait_wb(r);
    chk("b2b1_tag", 32'(r.tag), 32'h6);
    chk("b2b1_data", 32'(r.data), 32'h0000);
    wait_wb(r);
    chk("b2b2_tag", 32'(r.tag), 32'h7);
    chk("b2b2_data", 32'(r.data), 32'h0005);
    chk("b2b_alu_starts", 32'(n_sa), 32'd4);
    chk("b2b_other_starts", 32'(n_sl + n_ss), 32'd0);
    settle();

    // Undefined opcode goes to the ALU, which returns 0
    n_sa = 0;
    issue(opcode_t'(4'hD), 8'h03, 8'h04, 12'h000, 4'd8, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("undef_data", 32'(r.data), 32'h0000);
    chk("undef_alu_start_len", 32'(n_sa), 32'd2);
    settle();

    // Reset while MUL is in EXEC
    alu_lat = 4;
    issue(OP_MUL, 8'h10, 8'h10, 12'h000, 4'd9, acc);
    instr_valid = 1'b0;
    @(posedge clk); #3;
    rst = 1'b0;
    #1;
    chk("rstx_start_alu", 32'(start_alu), 32'h0);
    chk("rstx_alu_a", 32'(alu_a), 32'h0);
    chk("rstx_busy", 32'(busy), 32'h0);
    chk("rstx_ready", 32'(instr_ready), 32'h0);
    chk("rstx_wb_valid", 32'(wb_valid), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("rstx_no_wb", 32'(wbq.size()), 32'h0);
    alu_lat = 1;
    issue(OP_ADD, 8'h05, 8'h03, 12'h000, 4'd3, acc);
    instr_valid = 1'b0;
    wait_wb(r);
    chk("rstx_add_data", 32'(r.data), 32'h0008);
    chk("rstx_add_tag", 32'(r.tag), 32'h3);
    settle();

    // LOAD that never completes
    ld_lat = 1000000; n_sl = 0;
    issue(OP_LOAD, 8'h00, 8'h00, 12'h123, 4'd10, acc);
    instr_valid = 1'b0;
`ifdef OP_DISPATCH_WATCHDOG_EN
    wait_wb(r);
    chk("wd_data", 32'(r.data), 32'hFFFF);
    chk("wd_err", 32'(r.er), 32'h1);
    chk("wd_tag", 32'(r.tag), 32'hA);
    chk("wd_start_len", 32'(n_sl), 32'(TB_TIMEOUT));
    chk("wd_latency", 32'(r.cyc - acc), 32'(TB_TIMEOUT + 1));
    settle();
`else
    repeat (40) @(negedge clk);
    chk("hang_busy", 32'(busy), 32'h1);
    chk("hang_start_load", 32'(start_load), 32'h1);
    chk("hang_no_wb", 32'(wbq.size()), 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish (cycle %0d)", cyc);
    $fatal(1, "global timeout");
  end

endmodule

// File: doc/op_dispatch.md
Name: op_dispatch

Overview:
- Per-core issue stage that sits directly upstream of the ALU and the load and store units.
- Accepts one decoded instruction at a time over a valid/ready handshake and routes it to the correct execution unit.
- Holds that unit's start line until the unit reports completion, captures the result, and presents it to register-file writeback as a one-cycle tagged pulse.
- Strictly one instruction in flight.

Parameters:
- TAG_W, 4: width of the instruction/destination tag carried through to writeback.
- TIMEOUT, 255: watchdog limit in EXEC cycles (used only with the optional feature).

Ports:
- clk  in  1  core clock
- rst  in  1  asynchronous, active-low reset
- instr_valid  in  1  upstream instruction valid
- instr_ready  out  1  dispatcher can accept
- instr_op  in  opcode  pkg opcode type
- instr_a  in  8  operand A
- instr_b  in  8  operand B / store data
- instr_addr  in  12  load/store address
- instr_tag  in  TAG_W  destination tag
- alu_a, alu_b  out  8  ALU operands
- alu_op  out  opcode  ALU op select
- start_alu  out  1  ALU start, held until done
- end_alu  in  1  ALU done
- result_alu  in  16  ALU result
- ld_addr  out  12  load address
- start_load  out  1  load start
- end_load  in  1  load done
- result_load  in  16  load data, valid while end_load=1
- st_addr  out  12  store address
- st_data  out  8  store data
- start_store  out  1  store start
- end_store  in  1  store done
- wb_valid  out  1  one-cycle writeback strobe
- wb_tag  out  TAG_W  writeback tag
- wb_data  out  16  writeback data
- wb_is_store  out  1  completed op was STORE (no register write)
- busy  out  1  instruction in flight
- err  out  1  watchdog abort flag on writeback

Behaviour:
- Reset:
  - rst low asynchronously forces state IDLE and drops any in-flight instruction.
  - All outputs go to 0 (instr_ready=0 while rst low); all operand/tag registers clear.
- FSM, three states:
  - IDLE:
    - instr_ready=1, busy=0.
    - On instr_valid&instr_ready, latch op/a/b/addr/tag.
    - NOP goes straight to WB with data 0; any other op goes to EXEC.
  - EXEC:
    - busy=1. Exactly one start_* is high, chosen by latched op:
      - LOAD -> start_load
      - STORE -> start_store
      - all others -> start_alu
    - Operand outputs hold the latched values for the whole state.
    - When the selected end_* is 1, capture the result on that edge and go to WB:
      - ALU: result_alu
      - LOAD: result_load
      - STORE: 0
    - start_* falls on the same edge.
    - end_* of non-selected units is ignored.
  - WB:
    - wb_valid=1 for exactly one cycle; wb_tag and wb_data are driven from the captured registers.
    - wb_is_store=1 iff op was STORE.
    - All start_* are 0. Next state is IDLE unconditionally.
- Outputs are registered or decoded from state only; no combinational path from inputs to outputs.
- The start-deassert cycle is mandatory: load/store units return to idle on the FINISH-with-start edge, and the ALU clears end_alu only when start is low. The dispatcher must therefore never re-assert any start_* in the cycle immediately after EXEC.
- Latency:
  - accept -> wb_valid = 1 + N_exec + 1 cycles, where N_exec is the number of cycles start_* is high, including the end cycle.
  - Single-cycle ALU op: N_exec=2.
  - Maximum throughput: one instruction per N_exec+2 cycles.
- instr_valid while not ready: instruction held upstream; no capture.
- Unsupported or undefined opcode: routed to the ALU (ALU returns 0).
- Operand/address outputs are 0 whenever the corresponding start is 0.

Optional Feature:
- Macro OP_DISPATCH_WATCHDOG_EN.
- Defined:
  - An 8+-bit counter clears on EXEC entry and increments each EXEC cycle.
  - If it reaches TIMEOUT with no end_*, drop start_*, go to WB with wb_data=16'hFFFF and err=1 for that writeback cycle.
  - err=0 on all normal writebacks.
- Undefined:
  - No counter; EXEC waits indefinitely.
  - err tied 0.

Test Plan:
- Reset mid-EXEC: issue MUL, assert rst low in EXEC -> all outputs 0 immediately, no wb_valid after release, and the next ADD completes normally.
- ADD a=8'h05 b=8'h03 tag=3; ALU model asserts end_alu one cycle after start -> start_alu high 2 cycles, wb_valid 1 cycle later with wb_data=16'h0008, wb_tag=3; total 4 cycles accept-to-wb.
- MUL a=8'h10 b=8'h10; ALU model completes after 3 start cycles -> start_alu held through end cycle, wb_data=16'h0100, start_alu=0 in WB, instr_ready returns in the following cycle.
- LOAD addr=12'h2A0, load model misses then grants after 5 cycles with data 8'h5C -> start_load held to end_load, wb_data=16'h005C; STORE addr=12'h011 b=8'hA5 -> st_addr=12'h011, st_data=8'hA5, wb_is_store=1.
- Back-to-back: instr_valid held high with ADD then NOP then SUB -> each accepted only in IDLE, NOP yields wb_data=0 with no start_* pulse, three wb_valid pulses in order with correct tags.
- Watchdog build with TIMEOUT=8: LOAD with end_load never asserted -> start_load drops after 8 EXEC cycles, wb_valid with wb_data=16'hFFFF, err=1. Non-watchdog build: dispatcher stays busy.
